// File: rtl/memory_writeback_pkg.sv
// memory_writeback_pkg: pipeline control bit positions and MEM/WB register layout
package memory_writeback_pkg;
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        misload;
    logic [4:0]  rd;
    logic [31:0] alu;
  } memwb_t;
endpackage

// File: rtl/memory_writeback_data_mem.sv
// data_mem: single-port word memory with synchronous write and registered read
module data_mem #(
  parameter int MEM_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic                         re,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;
  // store port; contents survive reset but no write lands while reset is held
  always_ff @(posedge clk or negedge rst_n)
    if (rst_n && we) mem_q[addr] <= wdata;
  // read samples the pre-store word, so a combined read/write returns old data
  always_ff @(posedge clk)
    if (re) rdata_q <= mem_q[addr];
  assign rdata = rdata_q;
endmodule

// File: rtl/memory_writeback.sv
// memory_writeback: MEM stage data access plus MEM/WB register feeding the register file
module memory_writeback
  import memory_writeback_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_EXMEM,
  input  logic [1:0]  wb_EXMEM,
  input  logic [2:0]  mem_EXMEM,
  input  logic [31:0] alu_result_EXMEM,
  input  logic [31:0] store_data_EXMEM,
  input  logic [4:0]  write_reg_EXMEM,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  write_reg_MEMWB,
  output logic [31:0] write_data_WB,
  output logic        write_en,
  output logic        align_err,
  output logic [31:0] retired
);
  localparam int AW = $clog2(MEM_WORDS);
  logic        misaligned, accept, store_en, unused_branch;
  logic [31:0] load_data, retired_q;
  logic        align_err_q;
  memwb_t      memwb_q, memwb_d;
  assign unused_branch = mem_EXMEM[BRANCH];
  assign misaligned = (mem_EXMEM[MEMREAD] || mem_EXMEM[MEMWRITE]) && (alu_result_EXMEM[1:0] != 2'b00);
  assign accept     = valid_EXMEM && !stall && !flush;
  assign store_en   = accept && mem_EXMEM[MEMWRITE] && !misaligned;
  data_mem #(.MEM_WORDS(MEM_WORDS)) u_data_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (store_en),
    .re    (accept),
    .addr  (alu_result_EXMEM[AW+1:2]),
    .wdata (store_data_EXMEM),
    .rdata (load_data)
  );
  // next MEM/WB entry: a flush forces an all-zero bubble
  always_comb begin
    memwb_d = flush ? '0 : '{valid: valid_EXMEM, regwrite: wb_EXMEM[REGWRITE],
                             memtoreg: wb_EXMEM[MEMTOREG],
                             misload: misaligned && mem_EXMEM[MEMREAD],
                             rd: write_reg_EXMEM, alu: alu_result_EXMEM};
  end
  // MEM/WB register, sticky alignment flag and retire counter; stall freezes all three
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_q     <= '0;
      align_err_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      if (flush || !stall) memwb_q <= memwb_d;
      if (accept && misaligned) align_err_q <= 1'b1;
      if (accept) retired_q <= retired_q + 32'd1;
    end
  end
  assign write_reg_MEMWB = memwb_q.rd;
  assign write_data_WB   = memwb_q.memtoreg ? load_data : memwb_q.alu;
  assign write_en        = memwb_q.valid && memwb_q.regwrite && (memwb_q.rd != 5'd0) && !memwb_q.misload;
  assign align_err       = align_err_q;
  assign retired         = retired_q;
endmodule
